// File: rtl/isa_bus_cycle_decoder_if.sv
// Purpose: ISA-side bus and automate handshake bundle for isa_bus_cycle_decoder.
// Signals:
//   isa_sa[9:0], isa_aen, isa_ior_n, isa_iow_n : ISA bus inputs to the decoder
//   rdy                                        : completion from micro_program_automate
//   a[1:0], w, sel                             : select request to the automate
//   iochrdy, busy, timeout_err                 : bus stretch and status outputs
// Modports: slave = decoder side, master = ISA/automate side (bench or upstream logic).
interface isa_bus_cycle_decoder_if;
  logic [9:0] isa_sa;
  logic       isa_aen;
  logic       isa_ior_n;
  logic       isa_iow_n;
  logic       rdy;
  logic [1:0] a;
  logic       w;
  logic       sel;
  logic       iochrdy;
  logic       busy;
  logic       timeout_err;

  modport slave (
    input  isa_sa, isa_aen, isa_ior_n, isa_iow_n, rdy,
    output a, w, sel, iochrdy, busy, timeout_err
  );

  modport master (
    output isa_sa, isa_aen, isa_ior_n, isa_iow_n, rdy,
    input  a, w, sel, iochrdy, busy, timeout_err
  );
endinterface

// File: rtl/isa_bus_cycle_decoder.sv
// Purpose: detect ISA I/O read/write cycles addressed to the board, latch offset and
//   direction, request the micro-program automate (sel active low) and stretch the ISA
//   cycle with IOCHRDY until the automate answers with rdy.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : isa_bus_cycle_decoder_if.slave (ISA inputs, rdy in; a, w, sel, iochrdy,
//           busy, timeout_err out; all outputs registered)
// Parameters: BASE_ADDR (sa[9:2] match), WAIT_TIMEOUT (REQUEST abort limit, >= 2).
// Option: define CYCLE_TIMEOUT_EN to abort a REQUEST after WAIT_TIMEOUT cycles without rdy;
//   when undefined, REQUEST waits indefinitely and timeout_err stays 0.
module isa_bus_cycle_decoder #(
  parameter logic [9:0]  BASE_ADDR    = 10'h300,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  isa_bus_cycle_decoder_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, REQUEST, HOLD} state_t;

  state_t     state_q;
  logic [1:0] ior_sync_q;   // [0] first stage, [1] synchronised level
  logic [1:0] iow_sync_q;
  logic       ior_prev_q;
  logic       iow_prev_q;
  logic [1:0] a_q;
  logic       w_q;
  logic       sel_q;
  logic       iochrdy_q;
  logic       busy_q;
  logic       timeout_err_q;

  logic ior_s2_c;
  logic iow_s2_c;
  logic ior_fall_c;
  logic iow_fall_c;
  logic addr_hit_c;
  logic start_c;
  logic expire_c;

  // Strobe synchronisers plus previous-level flops for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ior_sync_q <= 2'b11;
      iow_sync_q <= 2'b11;
      ior_prev_q <= 1'b1;
      iow_prev_q <= 1'b1;
    end else begin
      ior_sync_q <= {ior_sync_q[0], bus.isa_ior_n};
      iow_sync_q <= {iow_sync_q[0], bus.isa_iow_n};
      ior_prev_q <= ior_sync_q[1];
      iow_prev_q <= iow_sync_q[1];
    end
  end

  assign ior_s2_c   = ior_sync_q[1];
  assign iow_s2_c   = iow_sync_q[1];
  assign ior_fall_c = ~ior_s2_c & ior_prev_q;
  assign iow_fall_c = ~iow_s2_c & iow_prev_q;
  assign addr_hit_c = (bus.isa_sa[9:2] == BASE_ADDR[9:2]);
  // One strobe falls while the other is high; both low at once is an invalid cycle
  assign start_c    = ~bus.isa_aen & addr_hit_c &
                      ((ior_fall_c & iow_s2_c) | (iow_fall_c & ior_s2_c));

`ifdef CYCLE_TIMEOUT_EN
  localparam int unsigned CNT_RAW_W = $clog2(WAIT_TIMEOUT);
  localparam int unsigned CNT_W     = (CNT_RAW_W < 8) ? 8 : ((CNT_RAW_W > 16) ? 16 : CNT_RAW_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Held at zero in IDLE so each REQUEST starts counting from 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (state_q == REQUEST) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_c = (cnt_q == LAST_CNT);
`else
  logic unused_wait_timeout;
  assign unused_wait_timeout = ^32'(WAIT_TIMEOUT);
  assign expire_c = 1'b0;
`endif

  // Cycle FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      a_q           <= 2'b00;
      w_q           <= 1'b0;
      sel_q         <= 1'b1;
      iochrdy_q     <= 1'b1;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_c) begin
            state_q       <= REQUEST;
            a_q           <= bus.isa_sa[1:0];
            w_q           <= iow_fall_c;
            sel_q         <= 1'b0;
            iochrdy_q     <= 1'b0;
            busy_q        <= 1'b1;
            timeout_err_q <= 1'b0;
          end
        end
        REQUEST: begin
          // rdy has priority over a simultaneous timeout
          if (bus.rdy) begin
            state_q   <= HOLD;
            sel_q     <= 1'b1;
            iochrdy_q <= 1'b1;
          end else if (expire_c) begin
            state_q       <= HOLD;
            sel_q         <= 1'b1;
            iochrdy_q     <= 1'b1;
            timeout_err_q <= 1'b1;
          end
        end
        HOLD: begin
          if (ior_s2_c && iow_s2_c) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.a           = a_q;
  assign bus.w           = w_q;
  assign bus.sel         = sel_q;
  assign bus.iochrdy     = iochrdy_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
